// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transmitter:
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmitter FSM state type
//   - baud divider calculation (clock cycles per bit, truncated)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Cycles per bit; integer division truncates toward zero.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO used to queue bytes in front of the UART transmitter.
// A push while full and a pop while empty are ignored.
//
// Parameters : WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
// Ports      : clk, rst_n    clock, asynchronous active-low reset
//              i_push/i_data write request and data
//              i_pop         read request (o_data shows the head entry)
//              o_full/o_empty occupancy flags
//              o_level       number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset: entries are only visible through the level count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with a valid/ready byte input. Frames are
// start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS
// stop bits; each bit lasts BAUD_DIV = CLK_FREQ / BAUD_RATE clock cycles.
//
// Build option UART_TX_FIFO_EN:
//   defined   - bytes are queued in a FIFO_DEPTH-entry uart_sync_fifo
//   undefined - a single holding register replaces the FIFO (level 0 or 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_valid    producer offers tx_data
//   tx_data     byte to transmit (DATA_BITS wide)
//   tx_ready    a byte can be accepted (buffer not full)
//   tx          serial line, idle high, registered
//   tx_busy     a frame is on the line
//   fifo_level  buffer occupancy
// -----------------------------------------------------------------------------
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BW       = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam int CW       = $clog2(DATA_BITS + 1);
  localparam int LW       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_FREQ / BAUD_RATE must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  logic                 w_push;
  logic                 w_pop;
  logic                 w_buf_full;
  logic                 w_buf_empty;
  logic [DATA_BITS-1:0] w_buf_data;

  // tx_ready ignores a same-cycle pop, so a full buffer never accepts.
  assign w_push   = tx_valid && !w_buf_full;
  assign tx_ready = !w_buf_full;

`ifdef UART_TX_FIFO_EN
  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_buf_data),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_level (fifo_level)
  );
`else
  logic                 r_hold_vld;
  logic [DATA_BITS-1:0] r_hold_data;

  assign w_buf_full  = r_hold_vld;
  assign w_buf_empty = !r_hold_vld;
  assign w_buf_data  = r_hold_data;
  assign fifo_level  = {{(LW-1){1'b0}}, r_hold_vld};

  // Push and pop are mutually exclusive: push needs empty, pop needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld <= 1'b0;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_hold_data <= tx_data;
  end
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_t            r_state;
  logic [BW-1:0]        r_baud_cnt;
  logic [CW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_bit_end;
  logic                 w_last_stop;

  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_last_stop = w_bit_end && (r_bit_cnt == STOP_LAST);

  // Pop from IDLE, or at the end of the last stop bit so the next start bit
  // follows with no idle cycle.
  assign w_pop = !w_buf_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last_stop));

  assign tx      = r_tx;
  assign tx_busy = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      // Counter is held at 0 while idle so the start bit gets a full period.
      r_baud_cnt <= ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_baud_cnt + 1'b1;

      if (w_pop) begin
        r_shift <= w_buf_data;
        r_par   <= parity_bit(w_buf_data);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              if (w_pop) begin
                r_tx    <= 1'b0;
                r_state <= ST_START;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Four transmitter instances (BAUD_DIV = 10):
//   0: 8N1  1: 8E1  2: 8O1  3: 7N2
// Stimulus pushes the expected line pattern of each frame into a scoreboard
// queue; one monitor per instance detects start bits, pops the matching entry
// and checks every cycle of every bit, the start cycle and back-to-back gaps.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int NI   = 4;
  localparam int BDIV = 10;

  typedef struct {
    int          k;
    logic [15:0] bits;
    int          nbits;
    int          start;
    bit          chain;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       tx_valid_a [NI];
  logic [7:0] tx_data_a  [NI];
  logic       tx_ready_a [NI];
  logic       tx_a       [NI];
  logic       tx_busy_a  [NI];
  logic [4:0] lvl_a      [NI];

  int     cyc;
  int     ncmp;
  int     nfail;
  frame_t sb[$];
  logic [NI-1:0] mon_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB  = (g == 3) ? 7 : 8;
    localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;
    logic       w_rdy;
    logic       w_tx;
    logic       w_busy;
    logic [4:0] w_lvl;

    uart_tx_param #(
      .CLK_FREQ   (1000000),
      .BAUD_RATE  (100000),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (16)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid_a[g]),
      .tx_data    (tx_data_a[g][DB-1:0]),
      .tx_ready   (w_rdy),
      .tx         (w_tx),
      .tx_busy    (w_busy),
      .fifo_level (w_lvl)
    );

    assign tx_ready_a[g] = w_rdy;
    assign tx_a[g]       = w_tx;
    assign tx_busy_a[g]  = w_busy;
    assign lvl_a[g]      = w_lvl;
  end

  task automatic check(input string name, input int got, input int exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    logic [15:0] b;
    b      = '0;
    b[0]   = 1'b0;
    b[8:1] = d;
    b[9]   = 1'b1;
    return b;
  endfunction

  // Offer one byte on instance k and queue its expected frame.
  task automatic push(input int k, input logic [7:0] d, input logic [15:0] bits,
                      input int nbits, input bit chk_lat, input bit chain);
    frame_t f;
    int     t;
    tx_valid_a[k] = 1'b1;
    tx_data_a[k]  = d;
    t = 0;
    while (!tx_ready_a[k] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      ncmp++;
      nfail++;
      $display("FAIL push_ready_timeout[%0d]: ready stayed 0", k);
    end else begin
      f.k     = k;
      f.bits  = bits;
      f.nbits = nbits;
      f.start = chk_lat ? cyc + 2 : -1;
      f.chain = chain;
      sb.push_back(f);
    end
    @(negedge clk);
    tx_valid_a[k] = 1'b0;
  endtask

  task automatic monitor(input int k);
    int     idx;
    int     st;
    int     prev_end;
    frame_t f;
    bit     abort;
    bit     bad;
    logic   seen;
    prev_end = -1;
    @(negedge clk);
    forever begin
      while (!(rst_n === 1'b1 && tx_a[k] === 1'b0)) @(negedge clk);
      st  = cyc;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].k == k) idx = i;
      if (idx < 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_frame[%0d]: start at cycle %0d, none queued", k, st);
        while (tx_a[k] === 1'b0) @(negedge clk);
        continue;
      end
      mon_busy[k] = 1'b1;
      f = sb[idx];
      sb.delete(idx);
      if (f.start >= 0) check($sformatf("start_cycle[%0d]", k), st, f.start);
      if (f.chain)      check($sformatf("b2b_gap[%0d]", k), st, prev_end);
      abort = 0;
      for (int b = 0; b < f.nbits && !abort; b++) begin
        bad  = 0;
        seen = f.bits[b];
        for (int c = 0; c < BDIV && !abort; c++) begin
          if (rst_n !== 1'b1) abort = 1;
          else begin
            if (tx_a[k] !== f.bits[b]) begin
              bad  = 1;
              seen = tx_a[k];
            end
            @(negedge clk);
          end
        end
        if (!abort) begin
          ncmp++;
          if (bad) begin
            nfail++;
            $display("FAIL frame_bit[%0d] bit %0d: line %0b, expected %0b", k, b, seen, f.bits[b]);
          end
        end
      end
      prev_end    = abort ? -1 : cyc;
      mon_busy[k] = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || mon_busy != '0) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t >= 6000) ? 1 : 0, 0);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
  end

  initial begin
    int n;
    int tcnt;
    int lowcnt;
    int busycnt;
    int acc0;
    int acc1;
    int exp_q;

    cyc      = 0;
    ncmp     = 0;
    nfail    = 0;
    mon_busy = '0;
    rst_n    = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tx_valid_a[i] = 1'b0;
      tx_data_a[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_tx", tx_a[0], 1);
    check("reset_ready", tx_ready_a[0], 1);
    check("reset_busy", tx_busy_a[0], 0);
    check("reset_level", lvl_a[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    push(0, 8'hA5, 16'h034A, 10, 1'b1, 1'b0);
    busycnt = 0;
    for (int t = 0; t < 300; t++) begin
      if (tx_busy_a[0]) busycnt++;
      else if (busycnt > 0) break;
      @(negedge clk);
    end
    check("busy_cycles_8n1", busycnt, 100);

    // 8E1 0x07 -> parity 1; 8O1 0x07 -> parity 0; 7N2 0x7F
    push(1, 8'h07, 16'h060E, 11, 1'b1, 1'b0);
    push(2, 8'h07, 16'h040E, 11, 1'b1, 1'b0);
    push(3, 8'h7F, 16'h03FE, 10, 1'b1, 1'b0);
    drain();

`ifdef UART_TX_FIFO_EN
    // Hold valid with 0x00..0x10: 17 accepted on consecutive edges, then full.
    n    = 0;
    tcnt = 0;
    tx_valid_a[0] = 1'b1;
    for (int t = 0; t < 40 && n < 17; t++) begin
      tx_data_a[0] = 8'(n);
      if (tx_ready_a[0]) begin
        sb.push_back('{k: 0, bits: f8n1(8'(n)), nbits: 10,
                       start: (n == 0) ? cyc + 2 : -1, chain: (n != 0)});
        n++;
      end
      tcnt++;
      @(negedge clk);
    end
    tx_data_a[0] = 8'h11;
    check("burst_accepted", n, 17);
    check("burst_cycles", tcnt, 17);
    check("burst_ready_low", tx_ready_a[0], 0);
    check("burst_level_full", lvl_a[0], 16);
    @(negedge clk);
    tx_valid_a[0] = 1'b0;
    tcnt = 0;
    while (!tx_ready_a[0] && tcnt < 300) begin
      @(negedge clk);
      tcnt++;
    end
    check("ready_after_pop", tx_ready_a[0], 1);
    check("level_after_pop", lvl_a[0], 15);
    drain();
    exp_q = 3;
`else
    // Holding register: second byte waits for the first pop.
    n      = 0;
    lowcnt = 0;
    acc0   = 0;
    acc1   = 0;
    tx_valid_a[0] = 1'b1;
    for (int t = 0; t < 10 && n < 2; t++) begin
      tx_data_a[0] = (n == 0) ? 8'h3C : 8'hC3;
      if (tx_ready_a[0]) begin
        sb.push_back('{k: 0, bits: f8n1(tx_data_a[0]), nbits: 10,
                       start: (n == 0) ? cyc + 2 : -1, chain: (n != 0)});
        if (n == 0) acc0 = cyc;
        else        acc1 = cyc;
        n++;
      end else begin
        lowcnt++;
      end
      @(negedge clk);
    end
    tx_valid_a[0] = 1'b0;
    check("hold_accepted", n, 2);
    check("hold_ready_low_cycles", lowcnt, 1);
    check("hold_accept_spacing", acc1 - acc0, 2);
    check("hold_level", lvl_a[0], 1);
    drain();
    exp_q = 1;
`endif

    // Reset in the middle of a frame of zeros with bytes still queued.
    push(0, 8'h00, f8n1(8'h00), 10, 1'b1, 1'b0);
    for (int i = 0; i < exp_q; i++) push(0, 8'h00, f8n1(8'h00), 10, 1'b0, 1'b1);
    check("prereset_level", lvl_a[0], exp_q);
    repeat (25) @(negedge clk);
    check("prereset_tx_data_bit", tx_a[0], 0);
    check("prereset_busy", tx_busy_a[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx_a[0], 1);
    check("async_reset_busy", tx_busy_a[0], 0);
    check("async_reset_level", lvl_a[0], 0);
    repeat (3) @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].k == 0) sb.delete(i);
    rst_n  = 1'b1;
    lowcnt = 0;
    busycnt = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1) lowcnt++;
      if (tx_busy_a[0] !== 1'b0) busycnt++;
    end
    check("postreset_level", lvl_a[0], 0);
    check("postreset_tx_low_cycles", lowcnt, 0);
    check("postreset_busy_cycles", busycnt, 0);
    check("postreset_ready", tx_ready_a[0], 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, FIFO-buffered UART transmitter. Successor to the fixed 8N1 transmitter: data width, parity mode and stop-bit count are configurable, and a valid/ready byte interface feeds an internal FIFO so that frames can go out back-to-back. It sits between the on-chip producer (command/response logic) and the board-level `tx` pin.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s. `BAUD_DIV = CLK_FREQ / BAUD_RATE`, truncated. `BAUD_DIV` must be ≥ 2; elaboration error otherwise.
- `DATA_BITS`, 8, payload bits per frame (5–9).
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame (1 or 2).
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  producer has a byte.
- `tx_data`  in  DATA_BITS  byte to send, transmitted LSB first.
- `tx_ready`  out  1  block can accept a byte. Reset value 1.
- `tx`  out  1  serial line, idle high. Reset value 1.
- `tx_busy`  out  1  a frame is on the line. Reset value 0.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy. Reset value 0.

## Operation
- **Accept:** a byte is accepted on any edge where `tx_valid && tx_ready`. `tx_ready = !fifo_full`, so no byte is accepted while the FIFO is full, even if a pop happens in the same cycle.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** when the FIFO is not empty, pop one entry, load the shift register, drive `tx` = 0, go to START.
- **START → DATA:** after one bit period.
- **DATA:** shift out `DATA_BITS` bits LSB first. After the last bit go to PARITY if `PARITY != 0`, otherwise go to STOP.
- **Parity bit:** even = XOR of the data bits; odd = inverted XOR.
- **STOP:** drive `tx` = 1 for `STOP_BITS` bit periods.
- **End of STOP:** if the FIFO is not empty, pop and go straight to START with no idle cycle. Otherwise go to IDLE.
- **Bit timing:** every bit lasts exactly `BAUD_DIV` cycles. The baud counter is $clog2(BAUD_DIV) bits wide, resets to 0 at each bit boundary, and wraps at `BAUD_DIV-1`.
- **Bit counter:** counts data bits and stop bits, $clog2(DATA_BITS+1) bits wide.
- **`tx` is registered:** no combinational path from the inputs.
- **Reset:** reset mid-frame forces `tx` = 1, `tx_busy` = 0, state IDLE and an empty FIFO immediately. The partial frame is lost.

## Timing
- **Latency:** a byte accepted at edge E into an empty, idle block pops at edge E+1, and `tx` goes low after E+1.
- **`tx_busy`:** rises at the pop edge and falls at the edge that ends the last stop bit, but only if nothing is queued. It stays high across back-to-back frames.
- **Frame length:** `BAUD_DIV × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)` cycles.
- **`fifo_level`:** updates on the edge after a push or pop. A simultaneous push and pop leaves it unchanged.
- **Throughput:** while the FSM holds one byte, the FIFO accepts `FIFO_DEPTH` more, so `FIFO_DEPTH+1` bytes are accepted in total before `tx_ready` falls. `tx_ready` rises on the edge after the next pop.

## Configuration
- Macro: `UART_TX_FIFO_EN`.
- **Defined:** FIFO of `FIFO_DEPTH` entries as described above.
- **Undefined:** the FIFO is replaced by a single holding register (depth 1). `tx_ready` is low while the holding register is full. `fifo_level` reads only 0 or 1. Frame timing and latency are identical in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - parity encodings `PAR_NONE` = 0, `PAR_ODD` = 1, `PAR_EVEN` = 2;
  - FSM state typedef;
  - function computing `BAUD_DIV`.
- **Sub-module `uart_sync_fifo`:** single-clock FIFO with push/pop, full/empty and level outputs, parametrised in width and depth. It is instantiated only under `UART_TX_FIFO_EN`.

## Test plan
Use `CLK_FREQ` = 1000000 and `BAUD_RATE` = 100000 (`BAUD_DIV` = 10) unless a scenario states otherwise.
- **8N1 frame:** push 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. `tx` falls 1 cycle after acceptance. `tx_busy` is high for exactly 100 cycles.
- **Parity:** `PARITY` = 2, push 0x07 → parity bit 1, 110-cycle frame. `PARITY` = 1, push 0x07 → parity bit 0.
- **Width and stop bits:** `DATA_BITS` = 7, `STOP_BITS` = 2, push 0x7F → start, seven 1s, two stop bits. `tx` is high for 90 cycles after the start bit.
- **Back-to-back and full:** hold `tx_valid` high with data 0x00..0x10 → 17 bytes accepted, then `tx_ready` = 0 and `fifo_level` = 16. Frames follow each other with no idle gap and in order.
- **Reset mid-frame:** assert `rst_n` = 0 mid-data-bit with 3 bytes queued → `tx` = 1 and `tx_busy` = 0 immediately. After release, `fifo_level` = 0 and `tx` stays idle.
- **Macro undefined:** push 2 bytes back-to-back → second byte accepted only after the first pops. `tx_ready` is low for 1 cycle.
